// File: rtl/nabp_top.sv
// Parallel-beam backprojection engine: per angle, buffers one detector row from a registered-read
// ROM, then adds it into IMG_N column accumulators. Define NABP_DONE_HOLD_EN to hold done high until the next kick.
module nabp_top #(
    parameter int DATA_W    = 16,
    parameter int IMG_N     = 8,
    parameter int ANGLES    = 8,
    parameter int SG_ADDR_W = 6,
    parameter int ACC_W     = DATA_W + $clog2(ANGLES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     kick,
    input  logic [DATA_W-1:0]        sg_val,
    output logic                     done,
    output logic [SG_ADDR_W-1:0]     sg_addr,
    output logic                     busy,
    input  logic [$clog2(IMG_N)-1:0] rd_x,
    input  logic [$clog2(IMG_N)-1:0] rd_y,
    output logic [ACC_W-1:0]         rd_pixel
);

    localparam int X_W = $clog2(IMG_N);
    localparam int A_W = $clog2(ANGLES);

    localparam logic [X_W:0]   K_ONE  = (X_W+1)'(1);
    localparam logic [X_W:0]   K_LAST = (X_W+1)'(IMG_N);
    localparam logic [X_W:0]   K_LM1  = (X_W+1)'(IMG_N - 1);
    localparam logic [X_W-1:0] Y_ONE  = X_W'(1);
    localparam logic [X_W-1:0] Y_LAST = X_W'(IMG_N - 1);
    localparam logic [A_W-1:0] A_ONE  = A_W'(1);
    localparam logic [A_W-1:0] A_LAST = A_W'(ANGLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [A_W-1:0]         a_q, a_d;
    logic [X_W:0]           k_q, k_d;
    logic [X_W-1:0]         y_q, y_d;
    logic [SG_ADDR_W-1:0]   sg_addr_q, sg_addr_d;
    logic                   done_q, done_d;
    logic [DATA_W-1:0]      buf_q [IMG_N];
    logic [DATA_W-1:0]      buf_d [IMG_N];
    logic [ACC_W-1:0]       acc_q [IMG_N][IMG_N];
    logic [ACC_W-1:0]       acc_d [IMG_N][IMG_N];
    logic [X_W-1:0]         idx;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        k_d       = k_q;
        y_d       = y_q;
        sg_addr_d = '0;
        buf_d     = buf_q;
        acc_d     = acc_q;
        idx       = '0;
`ifdef NABP_DONE_HOLD_EN
        done_d    = done_q;
`else
        done_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (kick) begin
                    state_d = S_LOAD;
                    a_d     = '0;
                    k_d     = '0;
                    done_d  = 1'b0;
                    acc_d   = '{default: '{default: '0}};
                end
            end
            S_LOAD: begin
                // ROM data lags its address by one cycle, so cycle k captures word k-1
                if (k_q != '0)
                    buf_d[X_W'(k_q - K_ONE)] = sg_val;
                if (k_q == K_LAST) begin
                    state_d = S_ACCUM;
                    k_d     = '0;
                    y_d     = '0;
                end else begin
                    k_d = k_q + K_ONE;
                    if (k_q < K_LM1)
                        sg_addr_d = {a_q, X_W'(k_q + K_ONE)};
                end
            end
            S_ACCUM: begin
                for (int x = 0; x < IMG_N; x++) begin
                    idx = X_W'(x + int'(a_q) * int'(y_q));
                    acc_d[y_q][x] = acc_q[y_q][x] + ACC_W'(buf_q[idx]);
                end
                if (y_q == Y_LAST) begin
                    if (a_q == A_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_LOAD;
                        a_d       = a_q + A_ONE;
                        k_d       = '0;
                        sg_addr_d = {a_q + A_ONE, {X_W{1'b0}}};
                    end
                end else begin
                    y_d = y_q + Y_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            k_q       <= '0;
            y_q       <= '0;
            sg_addr_q <= '0;
            done_q    <= 1'b0;
            buf_q     <= '{default: '0};
            acc_q     <= '{default: '{default: '0}};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            k_q       <= k_d;
            y_q       <= y_d;
            sg_addr_q <= sg_addr_d;
            done_q    <= done_d;
            buf_q     <= buf_d;
            acc_q     <= acc_d;
        end
    end

    assign done     = done_q;
    assign sg_addr  = sg_addr_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_ACCUM);
    assign rd_pixel = acc_q[rd_y][rd_x];

endmodule

// File: tb/tb_nabp_top.sv
// Bench for nabp_top: sinogram ROM model, closed-form backprojection reference, timing and
// address-sequence checks, mid-run reset and ignored-kick scenarios.
module tb_nabp_top;

    localparam int N    = 8;
    localparam int ANG  = 8;
    localparam int DW   = 16;
    localparam int AW   = 6;
    localparam int ACCW = 19;
    localparam int PER  = 2 * N + 1;
    localparam int LAT  = ANG * PER + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            kick;
    logic [DW-1:0]   sg_val;
    logic            done;
    logic [AW-1:0]   sg_addr;
    logic            busy;
    logic [2:0]      rd_x, rd_y;
    logic [ACCW-1:0] rd_pixel;

    int checks = 0;
    int errors = 0;
    int lat;

    logic [DW-1:0] sg_mem [ANG*N];

    always #5 clk = ~clk;

    always @(posedge clk) sg_val <= sg_mem[sg_addr];

    nabp_top dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .kick     (kick),
        .sg_val   (sg_val),
        .done     (done),
        .sg_addr  (sg_addr),
        .busy     (busy),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_pixel (rd_pixel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pixel(x,y) = sum over angles of sample at detector bin (x + a*y) mod N, wrapped to ACCW bits
    function automatic int model_pixel(input int x, input int y);
        int sum = 0;
        for (int a = 0; a < ANG; a++)
            sum += int'(sg_mem[a*N + (x + a*y) % N]);
        return sum % (1 << ACCW);
    endfunction

    function automatic int exp_addr(input int c);
        int p = c / PER;
        int r = c % PER;
        return (p < ANG && r < N) ? p * N + r : 0;
    endfunction

    task automatic run(input bit inject, output int latency);
        int bad = 0;
        int nonzero = 0;
        latency = -1;
        kick = 1'b1;
        @(posedge clk); #1;
        kick = 1'b0;
        for (int c = 0; c <= LAT + 20; c++) begin
            if (sg_addr !== AW'(exp_addr(c))) bad++;
            if (sg_addr != '0) nonzero++;
            if (c == 0) begin
                check("busy_start", busy, 1);
                check("done_cleared", done, 0);
            end
            if (c == LAT - 2) check("busy_last_accum", busy, 1);
            if (c == LAT - 1) check("busy_in_done", busy, 0);
            if (done === 1'b1) begin
                latency = c;
                break;
            end
            kick = inject && (c == 30 || c == 100);
            @(posedge clk); #1;
        end
        kick = 1'b0;
        check("latency", latency, LAT);
        check("addr_seq_errors", bad, 0);
        check("addr_nonzero_count", nonzero, ANG * N - 1);
    endtask

    task automatic check_pixels(input string tag);
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) begin
                rd_x = 3'(x);
                rd_y = 3'(y);
                #1;
                check(tag, rd_pixel, model_pixel(x, y));
            end
        @(posedge clk); #1;
    endtask

    task automatic pixel_at(input int x, input int y, output int v);
        rd_x = 3'(x);
        rd_y = 3'(y);
        #1;
        v = int'(rd_pixel);
    endtask

    initial begin
        int v;
        int done_seen;
        reset_n = 1'b1;
        kick    = 1'b0;
        rd_x    = '0;
        rd_y    = '0;
        for (int i = 0; i < ANG*N; i++) sg_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", sg_addr, 0);
        check("rst_pixel", rd_pixel, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;

        // all-ones sinogram: every pixel sums to ANG
        for (int i = 0; i < ANG*N; i++) sg_mem[i] = 16'd1;
        run(1'b0, lat);
        check_pixels("ones_pixel");
        pixel_at(5, 6, v);
        check("ones_const", v, 8);
        @(posedge clk); #1;
`ifdef NABP_DONE_HOLD_EN
        check("done_held", done, 1);
`else
        check("done_pulse_low", done, 0);
`endif

        // ramp sinogram sg[a*N+b] = b
        for (int a = 0; a < ANG; a++)
            for (int b = 0; b < N; b++) sg_mem[a*N + b] = DW'(b);
        run(1'b0, lat);
        pixel_at(3, 0, v);
        check("ramp_p30", v, 24);
        pixel_at(1, 1, v);
        check("ramp_p11", v, 28);
        check_pixels("ramp_pixel");

        // random run followed back-to-back by an impulse run started in the idle cycle after done
        for (int i = 0; i < ANG*N; i++) sg_mem[i] = DW'($urandom);
        run(1'b0, lat);
        for (int i = 0; i < ANG*N; i++) sg_mem[i] = '0;
        sg_mem[0] = 16'd1;
        run(1'b0, lat);
        pixel_at(0, 5, v);
        check("impulse_col0", v, 1);
        pixel_at(4, 2, v);
        check("impulse_other", v, 0);
        check_pixels("impulse_pixel");

        // random data with kick pulses while busy
        for (int i = 0; i < ANG*N; i++) sg_mem[i] = DW'($urandom);
        run(1'b1, lat);
        check_pixels("rand_kick_pixel");

        // reset asserted at cycle 50 of a run
        for (int i = 0; i < ANG*N; i++) sg_mem[i] = DW'($urandom);
        kick = 1'b1;
        @(posedge clk); #1;
        kick = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", sg_addr, 0);
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) begin
                pixel_at(x, y, v);
                check("midrst_pixel", v, 0);
            end
        @(posedge clk); #1;
        reset_n = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run(1'b0, lat);
        check_pixels("after_rst_pixel");
`ifdef NABP_DONE_HOLD_EN
        repeat (5) @(posedge clk);
        #1;
        check("done_hold_long", done, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
